dcache_responder: RTL and testbench

Synthesizable responder for the integer unit's data-cache port: it stands in for the data cache and memory on the far side of the IU interface in the processor testbench. Services load and store requests from the IU against a small word-addressed memory, stalls the pipeline for a programmable latency, and returns load data with a strobe. Every store is exported on a capture port for the scoreboard, and a preload port lets the bench seed memory before or between instructions.

---
 rtl/dcache_resp_pkg.sv | 54 +++++
 rtl/dresp_mem.sv | 41 ++++
 rtl/dcache_responder.sv | 152 +++++++++++++++
 tb/tb_dcache_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_resp_pkg.sv
// rtl/dcache_resp_pkg.sv - shared types and byte-lane helpers for the data-cache responder
package dcache_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Big-endian lane placement: offset 0 is the most significant byte.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = old;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    r = {wdata[7:0], old[23:0]};
                    2'd1:    r = {old[31:24], wdata[7:0], old[15:0]};
                    2'd2:    r = {old[31:16], wdata[7:0], old[7:0]};
                    default: r = {old[31:8], wdata[7:0]};
                endcase
            end
            SZ_HALF: r = off[1] ? {old[31:16], wdata[15:0]} : {wdata[15:0], old[15:0]};
            SZ_WORD: r = wdata;
            default: r = old;
        endcase
        return r;
    endfunction

    // Size 3 has no legal alignment, so it is reported here as well.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dresp_mem.sv
// rtl/dresp_mem.sv - word memory with prioritised store/preload write and async read
module dresp_mem
    import dcache_resp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_we,
    input  logic [AW-1:0] st_idx,
    input  logic [31:0]   st_wdata,
    input  logic          pl_we,
    input  logic [AW-1:0] pl_idx,
    input  logic [31:0]   pl_wdata,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // A committed store owns its word; a preload to the same word that cycle is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (st_we && (st_idx == AW'(i))) begin
                    mem[i] <= st_wdata;
                end else if (pl_we && (pl_idx == AW'(i))) begin
                    mem[i] <= pl_wdata;
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - IU data-cache port responder with programmable stall latency
module dcache_responder
    import dcache_resp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [31:0]              req_addr,
    input  logic [1:0]               req_size,
    input  logic [31:0]              req_wdata,
    output logic                     hold_n,
    output logic                     mds_n,
    output logic [31:0]              rdata,
    output logic                     mexc,
    output logic                     st_valid,
    output logic [31:0]              st_addr,
    output logic [31:0]              st_data,
    input  logic                     pl_we,
    input  logic [$clog2(DEPTH)-1:0] pl_addr,
    input  logic [31:0]              pl_data
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic [31:0] lat_wdata;

    logic        cur_write;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [31:0] rd_word;
    logic [31:0] merged;
    logic        mem_st_we;

    // With zero latency the response is built straight from the request inputs.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_size  = lat_size;
        cur_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_size  = req_size;
            cur_wdata = req_wdata;
        end
        cur_err = misaligned(cur_size, cur_addr[1:0]) || (cur_addr[31:2] >= 30'(DEPTH));
        merged  = lane_merge(rd_word, cur_wdata, cur_size, cur_addr[1:0]);
    end

    // The merged word is written during the RESP cycle, so a load issued right after sees it.
    assign mem_st_we = (state == ST_RESP) && st_valid;

    dresp_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .st_we    (mem_st_we),
        .st_idx   (st_addr[AW+1:2]),
        .st_wdata (st_data),
        .pl_we    (pl_we),
        .pl_idx   (pl_addr),
        .pl_wdata (pl_data),
        .rd_idx   (cur_addr[AW+1:2]),
        .rd_data  (rd_word)
    );

    // Access FSM: accept in IDLE, count down the stall in WAIT, register the response into RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= 32'h0;
            lat_size  <= 2'd0;
            lat_wdata <= 32'h0;
            hold_n    <= 1'b1;
            mds_n     <= 1'b1;
            rdata     <= 32'h0;
            mexc      <= 1'b0;
            st_valid  <= 1'b0;
            st_addr   <= 32'h0;
            st_data   <= 32'h0;
        end else begin
            mds_n    <= 1'b1;
            mexc     <= 1'b0;
            st_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_size  <= req_size;
                        lat_wdata <= req_wdata;
                        if (LAT == 0) begin
                            state    <= ST_RESP;
                            mds_n    <= 1'b0;
                            mexc     <= cur_err;
                            rdata    <= (cur_err || cur_write) ? 32'h0 : rd_word;
                            st_valid <= cur_write && !cur_err;
                            if (cur_write && !cur_err) begin
                                st_addr <= {cur_addr[31:2], 2'b00};
                                st_data <= merged;
                            end
                        end else begin
                            state  <= ST_WAIT;
                            cnt    <= LAT_M1;
                            hold_n <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= ST_RESP;
                        hold_n   <= 1'b1;
                        mds_n    <= 1'b0;
                        mexc     <= cur_err;
                        rdata    <= (cur_err || cur_write) ? 32'h0 : rd_word;
                        st_valid <= cur_write && !cur_err;
                        if (cur_write && !cur_err) begin
                            st_addr <= {cur_addr[31:2], 2'b00};
                            st_data <= merged;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    hold_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - self-checking bench for dcache_responder at LAT=2 and LAT=0
module tb_dcache_responder;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][31:0] req_addr;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       hold_n;
    logic [1:0]       mds_n;
    logic [1:0][31:0] rdata;
    logic [1:0]       mexc;
    logic [1:0]       st_valid;
    logic [1:0][31:0] st_addr;
    logic [1:0][31:0] st_data;
    logic [1:0]       pl_we;
    logic [1:0][5:0]  pl_addr;
    logic [1:0][31:0] pl_data;

    logic [31:0] model_mem [2][64];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_responder #(.DEPTH(64), .LAT(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_size(req_size[0]), .req_wdata(req_wdata[0]),
        .hold_n(hold_n[0]), .mds_n(mds_n[0]), .rdata(rdata[0]), .mexc(mexc[0]),
        .st_valid(st_valid[0]), .st_addr(st_addr[0]), .st_data(st_data[0]),
        .pl_we(pl_we[0]), .pl_addr(pl_addr[0]), .pl_data(pl_data[0])
    );

    dcache_responder #(.DEPTH(64), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_size(req_size[1]), .req_wdata(req_wdata[1]),
        .hold_n(hold_n[1]), .mds_n(mds_n[1]), .rdata(rdata[1]), .mexc(mexc[1]),
        .st_valid(st_valid[1]), .st_addr(st_addr[1]), .st_data(st_data[1]),
        .pl_we(pl_we[1]), .pl_addr(pl_addr[1]), .pl_data(pl_data[1])
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] addr, input logic [1:0] size);
        if ((addr >> 2) >= 64) return 1'b1;
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input int off);
        int sh;
        logic [31:0] m;
        if (size == 2'd2) return wd;
        if (size == 2'd0) begin
            sh = (3 - off) * 8;
            m  = 32'hFF << sh;
            return (old & ~m) | ((wd & 32'hFF) << sh);
        end
        sh = (2 - off) * 8;
        m  = 32'hFFFF << sh;
        return (old & ~m) | ((wd & 32'hFFFF) << sh);
    endfunction

    task automatic preload(input int d, input int idx, input logic [31:0] v);
        pl_we[d]   = 1'b1;
        pl_addr[d] = 6'(idx);
        pl_data[d] = v;
        @(negedge clk);
        pl_we[d] = 1'b0;
        model_mem[d][idx] = v;
    endtask

    // Called at a negedge; returns at a negedge one cycle after the RESP cycle.
    task automatic access(input int d, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input bit pl_en, input int pl_idx,
                          input logic [31:0] pl_v, output logic [31:0] obs);
        int lat;
        bit err;
        int w;
        logic [31:0] exp_word;
        lat = (d == 0) ? 2 : 0;
        err = ref_err(addr, size);
        w   = int'(addr >> 2);
        exp_word = 32'h0;
        if (!err) exp_word = wr ? ref_merge(model_mem[d][w], wd, size, int'(addr % 4)) : model_mem[d][w];

        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_size[d]  = size;
        req_wdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk("stall_hold_n", d, 32'(hold_n[d]), 32'h0);
            chk("stall_mds_n", d, 32'(mds_n[d]), 32'h1);
            @(negedge clk);
        end
        chk("resp_hold_n", d, 32'(hold_n[d]), 32'h1);
        chk("resp_mds_n", d, 32'(mds_n[d]), 32'h0);
        chk("resp_mexc", d, 32'(mexc[d]), 32'(err));
        chk("resp_st_valid", d, 32'(st_valid[d]), 32'(wr && !err));
        if (!wr) begin
            chk("resp_rdata", d, rdata[d], exp_word);
            obs = rdata[d];
        end else begin
            obs = st_data[d];
            if (!err) begin
                chk("resp_st_addr", d, st_addr[d], addr & 32'hFFFF_FFFC);
                chk("resp_st_data", d, st_data[d], exp_word);
            end
        end
        if (pl_en) begin
            pl_we[d]   = 1'b1;
            pl_addr[d] = 6'(pl_idx);
            pl_data[d] = pl_v;
        end
        @(negedge clk);
        pl_we[d] = 1'b0;
        chk("after_mds_n", d, 32'(mds_n[d]), 32'h1);
        chk("after_st_valid", d, 32'(st_valid[d]), 32'h0);
        chk("after_hold_n", d, 32'(hold_n[d]), 32'h1);
        if (wr && !err) model_mem[d][w] = exp_word;
        if (pl_en && !(wr && !err && pl_idx == w)) model_mem[d][pl_idx] = pl_v;
    endtask

    task automatic ld(input int d, input logic [31:0] addr, input logic [1:0] size, output logic [31:0] obs);
        access(d, 1'b0, addr, size, 32'h0, 1'b0, 0, 32'h0, obs);
    endtask

    task automatic st(input int d, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wd, output logic [31:0] obs);
        access(d, 1'b1, addr, size, wd, 1'b0, 0, 32'h0, obs);
    endtask

    initial begin
        logic [31:0] obs;
        rst = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_size = '0; req_wdata = '0;
        pl_we = '0; pl_addr = '0; pl_data = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) model_mem[d][i] = 32'h0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_hold_n", d, 32'(hold_n[d]), 32'h1);
            chk("rst_mds_n", d, 32'(mds_n[d]), 32'h1);
            chk("rst_rdata", d, rdata[d], 32'h0);
            chk("rst_mexc", d, 32'(mexc[d]), 32'h0);
            chk("rst_st_valid", d, 32'(st_valid[d]), 32'h0);
            chk("rst_st_addr", d, st_addr[d], 32'h0);
            chk("rst_st_data", d, st_data[d], 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);

        // LAT=2 load timing
        preload(0, 4, 32'h0000_0100);
        ld(0, 32'h10, 2'd2, obs);
        chk("plan_timing_load", 0, obs, 32'h0000_0100);

        // byte and halfword merge
        preload(0, 1, 32'hAABB_CCDD);
        st(0, 32'h05, 2'd0, 32'h11, obs);
        chk("plan_merge_byte", 0, obs, 32'hAA11_CCDD);
        st(0, 32'h06, 2'd1, 32'h2233, obs);
        chk("plan_merge_half", 0, obs, 32'hAA11_2233);

        // error responses
        ld(0, 32'h100, 2'd2, obs);
        chk("plan_err_range_rdata", 0, obs, 32'h0);
        preload(0, 0, 32'h5A5A_0F0F);
        st(0, 32'h02, 2'd2, 32'hDEAD_BEEF, obs);
        ld(0, 32'h00, 2'd2, obs);
        chk("plan_err_mem_unchanged", 0, obs, 32'h5A5A_0F0F);
        ld(1, 32'h03, 2'd3, obs);
        st(1, 32'h21, 2'd1, 32'hFFFF, obs);

        // LAT=0 store then load back
        st(1, 32'h14, 2'd2, 32'd11, obs);
        chk("plan_lat0_store", 1, obs, 32'h0000_000B);
        ld(1, 32'h14, 2'd2, obs);
        chk("plan_lat0_load", 1, obs, 32'd11);

        // preload colliding with the committing store
        access(0, 1'b1, 32'h0C, 2'd2, 32'h1234_5678, 1'b1, 3, 32'hFFFF_FFFF, obs);
        ld(0, 32'h0C, 2'd2, obs);
        chk("plan_collision", 0, obs, 32'h1234_5678);
        access(1, 1'b1, 32'h0C, 2'd2, 32'h0BAD_F00D, 1'b1, 9, 32'h7777_0000, obs);
        ld(1, 32'h24, 2'd2, obs);
        chk("plan_both_written", 1, obs, 32'h7777_0000);

        // randomized traffic against the reference memory
        for (int i = 0; i < 120; i++) begin
            int d;
            d = i % 2;
            if ($urandom_range(0, 3) == 0) begin
                preload(d, int'($urandom_range(0, 63)), $urandom);
            end else begin
                logic [31:0] a;
                a = ($urandom_range(0, 70) << 2) | $urandom_range(0, 3);
                access(d, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom,
                       ($urandom_range(0, 2) == 0), int'($urandom_range(0, 63)), $urandom, obs);
            end
        end

        // reset during the WAIT of a store
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h08;
        req_size[0] = 2'd2; req_wdata[0] = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("abort_wait_hold_n", 0, 32'(hold_n[0]), 32'h0);
        rst = 1'b0;
        #1;
        chk("abort_hold_n", 0, 32'(hold_n[0]), 32'h1);
        chk("abort_st_valid", 0, 32'(st_valid[0]), 32'h0);
        chk("abort_mds_n", 0, 32'(mds_n[0]), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) model_mem[d][i] = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_st_valid", 0, 32'(st_valid[0]), 32'h0);
        end
        ld(0, 32'h08, 2'd2, obs);
        chk("plan_abort_load", 0, obs, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
